scroll_ctrl: RTL
================

// Module: scroll_ctrl
// PURPOSE
//  Parametrised scroll sequencer for the word panel. It replaces clock gating with a registered
//  one-cycle shift_en strobe and a column offset into the message buffer. Supports run/pause
//  toggling from a debounced button, a 4-step speed select, and wrap or bounce scroll modes.
//  Sits between the panel button input and the column/row driver, which reads offset on shift_en.
// PARAMETERS
//  RATE_DIV   25_000_000  clk cycles per scroll step at speed=0 (4 Hz at 100 MHz)
//  MSG_COLS   64          message length in columns; must be > DISP_COLS
//  DISP_COLS  8           visible panel width in columns; must be >= 1
//  DB_CYCLES  500_000     cycles the button must be stable to register a level change
//  OW         $clog2(MSG_COLS)  offset width (localparam, not overridable)
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous active-low reset
//  btn       in   1   raw, asynchronous panel button
//  restart   in   1   synchronous; abort scroll, offset to 0, go IDLE
//  bounce    in   1   0 = wrap mode, 1 = bounce mode; sampled only on step ticks
//  speed     in   2   step period = RATE_DIV << speed (0 fastest, 3 slowest)
//  offset    out  OW  first visible message column
//  shift_en  out  1   one-cycle strobe; offset holds new value in the same cycle
//  running   out  1   high in RUN
//  err       out  1   sticky illegal-state flag
// BEHAVIOUR
//  Reset (rst_n=0, any time): state=IDLE, offset=0, shift_en=0, running=0, err=0, prescaler=0,
//   dir=up, debouncer cleared to released. The design is async-assert; release is synchronised
//   to clk by the top level.
//  Button path: 2-FF synchroniser, then a stability counter. The level updates after DB_CYCLES
//   consecutive equal samples. press = one-cycle pulse on the debounced 0->1 edge. Release
//   produces no event.
//  FSM, 2-bit encoding IDLE=00, RUN=01, PAUSE=10:
//   IDLE : press -> RUN; prescaler held at 0
//   RUN  : press -> PAUSE; prescaler counts
//   PAUSE: press -> RUN; prescaler and offset frozen, not cleared
//   encoding 11 -> err<=1, next state IDLE, offset<=0
//   restart (any state) -> IDLE, offset<=0, dir<=up, prescaler<=0. restart wins over press
//   in the same cycle.
//  Tick: in RUN, when prescaler == (RATE_DIV<<speed)-1, the prescaler goes to 0 and a tick fires.
//   A speed change mid-count takes effect against the current count. If the count is already
//   past the new limit, the tick fires on the next cycle.
//  On tick (registered, one cycle after the terminal count):
//   wrap mode  : offset <= (offset==MSG_COLS-1) ? 0 : offset+1
//   bounce mode: max = MSG_COLS-DISP_COLS
//    dir up  : at max, dir<=down and offset<=max-1; otherwise offset+1
//    dir down: at 0, dir<=up and offset<=1; otherwise offset-1
//    switching into bounce with offset>max: offset<=max, dir<=down
//   shift_en=1 in the same cycle the new offset appears; otherwise 0.
//  press and tick in the same cycle, RUN->PAUSE: the tick is still applied.
//  running = (state==RUN), registered.
//  Width rule: prescaler width is $clog2(RATE_DIV<<3). offset arithmetic stays within OW bits
//   with no overflow.
// STRUCTURE
//  Package scroll_pkg: typedef enum logic [1:0] {IDLE,RUN,PAUSE} scroll_state_t;
//   typedef enum logic {DIR_UP,DIR_DOWN} scroll_dir_t.
//  Sub-module btn_debounce (#DB_CYCLES): clk, rst_n, btn_raw -> level, press.
//  The top holds the FSM, the prescaler, and the offset/dir registers.
// TESTING  (RATE_DIV=4, MSG_COLS=8, DISP_COLS=3, DB_CYCLES=3)
//  1 btn high for 2 cycles, then low -> no press, state IDLE, offset 0.
//  2 btn held 10 cycles, speed=0, bounce=0 -> running=1; shift_en every 4 cycles;
//    offset 1..7, then 0.
//  3 bounce=1 from RUN -> offset 0,1,..,5,4,..,0,1; max=5, each value held one tick.
//  4 press in RUN at offset 3, wait 40 cycles, press again -> no shift_en while paused;
//    the next step is 4 after the residual count.
//  5 speed=2 -> shift_en period 16 cycles; restart and press in the same cycle
//    -> IDLE, offset 0.
//  6 rst_n low mid-RUN at offset 5 -> all outputs 0 immediately (asynchronous);
//    force state 11 -> err=1, state IDLE.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared types for the word-panel scroll sequencer.
package scroll_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } scroll_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } scroll_dir_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, and a one-cycle
// pulse on each debounced press. Releasing the button produces no event.
module btn_debounce #(
  parameter int DB_CYCLES = 500_000,
  localparam int CW = $clog2(DB_CYCLES + 32'd1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 32'd1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;
  logic          level_r;
  logic          press_r;

  // Synchronise the raw button and accept a new level once it has been stable long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
      if (sync2_r == level_r) begin
        cnt_r   <= {CW{1'b0}};
        press_r <= 1'b0;
      end else if (cnt_r == CNT_LAST) begin
        cnt_r   <= {CW{1'b0}};
        level_r <= sync2_r;
        press_r <= sync2_r;
      end else begin
        cnt_r   <= cnt_r + CNT_ONE;
        press_r <= 1'b0;
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/scroll_ctrl.sv
// Scroll sequencer: run/pause FSM, speed-scaled step prescaler and the
// offset/direction registers that drive the panel column reader.
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int RATE_DIV  = 25_000_000,
  parameter int MSG_COLS  = 64,
  parameter int DISP_COLS = 8,
  parameter int DB_CYCLES = 500_000,
  localparam int OW = $clog2(MSG_COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          btn,
  input  logic          restart,
  input  logic          bounce,
  input  logic [1:0]    speed,
  output logic [OW-1:0] offset,
  output logic          shift_en,
  output logic          running,
  output logic          err
);

  localparam int PW = $clog2(RATE_DIV << 32'd3);

  localparam logic [PW-1:0] PRE_ONE    = PW'(32'd1);
  localparam logic [OW-1:0] OFF_ONE    = OW'(32'd1);
  localparam logic [OW-1:0] OFF_LAST   = OW'(MSG_COLS - 32'd1);
  localparam logic [OW-1:0] OFF_MAX    = OW'(MSG_COLS - DISP_COLS);
  localparam logic [OW-1:0] OFF_MAX_M1 = OW'(MSG_COLS - DISP_COLS - 32'd1);

  logic          rst_meta_r;
  logic          rst_sync_n_r;
  logic          level_s;
  logic          press_s;
  logic          btn_press_s;
  logic [31:0]   limit_s;
  logic          tick_s;
  logic          illegal_s;
  scroll_state_t fsm_next_s;
  scroll_state_t state_next_s;
  logic [PW-1:0] pre_next_s;
  logic [OW-1:0] off_next_s;
  scroll_dir_t   dir_next_s;

  scroll_state_t state_r;
  scroll_dir_t   dir_r;
  logic [PW-1:0] pre_r;
  logic [OW-1:0] offset_r;
  logic          shift_en_r;
  logic          running_r;
  logic          err_r;

  // Assert reset asynchronously, release it on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_r   <= 1'b0;
      rst_sync_n_r <= 1'b0;
    end else begin
      rst_meta_r   <= 1'b1;
      rst_sync_n_r <= rst_meta_r;
    end
  end

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
    .clk     (clk),
    .rst_n   (rst_sync_n_r),
    .btn_raw (btn),
    .level   (level_s),
    .press   (press_s)
  );

  // A press pulse is only ever legitimate while the debounced level is high.
  assign btn_press_s = press_s & level_s;

  // >= rather than == so a speed cut below the current count still steps next cycle.
  assign limit_s = (32'(RATE_DIV) << speed) - 32'd1;
  assign tick_s  = (state_r == RUN) && (32'(pre_r) >= limit_s);

  // Next-state decode; restart overrides any button activity.
  always_comb begin
    fsm_next_s   = state_r;
    state_next_s = IDLE;
    illegal_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (btn_press_s) fsm_next_s = RUN;
        else             fsm_next_s = IDLE;
      end
      RUN: begin
        if (btn_press_s) fsm_next_s = PAUSE;
        else             fsm_next_s = RUN;
      end
      PAUSE: begin
        if (btn_press_s) fsm_next_s = RUN;
        else             fsm_next_s = PAUSE;
      end
      default: begin
        fsm_next_s = IDLE;
        illegal_s  = 1'b1;
      end
    endcase
    if (restart) state_next_s = IDLE;
    else         state_next_s = fsm_next_s;
  end

  // Prescaler: cleared in IDLE, counting in RUN, frozen in PAUSE.
  always_comb begin
    pre_next_s = pre_r;
    if (restart) begin
      pre_next_s = {PW{1'b0}};
    end else begin
      case (state_r)
        IDLE:  pre_next_s = {PW{1'b0}};
        RUN: begin
          if (tick_s) pre_next_s = {PW{1'b0}};
          else        pre_next_s = pre_r + PRE_ONE;
        end
        PAUSE: pre_next_s = pre_r;
        default: pre_next_s = {PW{1'b0}};
      endcase
    end
  end

  // Offset stepping for wrap and bounce modes.
  always_comb begin
    off_next_s = offset_r;
    dir_next_s = dir_r;
    if (restart) begin
      off_next_s = {OW{1'b0}};
      dir_next_s = DIR_UP;
    end else if (illegal_s) begin
      off_next_s = {OW{1'b0}};
      dir_next_s = dir_r;
    end else if (tick_s) begin
      if (!bounce) begin
        if (offset_r == OFF_LAST) off_next_s = {OW{1'b0}};
        else                      off_next_s = offset_r + OFF_ONE;
      end else if (offset_r > OFF_MAX) begin
        off_next_s = OFF_MAX;
        dir_next_s = DIR_DOWN;
      end else if (dir_r == DIR_UP) begin
        if (offset_r == OFF_MAX) begin
          off_next_s = OFF_MAX_M1;
          dir_next_s = DIR_DOWN;
        end else begin
          off_next_s = offset_r + OFF_ONE;
        end
      end else begin
        if (offset_r == {OW{1'b0}}) begin
          off_next_s = OFF_ONE;
          dir_next_s = DIR_UP;
        end else begin
          off_next_s = offset_r - OFF_ONE;
        end
      end
    end else begin
      off_next_s = offset_r;
      dir_next_s = dir_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_sync_n_r) begin
    if (!rst_sync_n_r) begin
      state_r    <= IDLE;
      dir_r      <= DIR_UP;
      pre_r      <= {PW{1'b0}};
      offset_r   <= {OW{1'b0}};
      shift_en_r <= 1'b0;
      running_r  <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      dir_r      <= dir_next_s;
      pre_r      <= pre_next_s;
      offset_r   <= off_next_s;
      shift_en_r <= tick_s & ~restart;
      running_r  <= (state_next_s == RUN);
      err_r      <= err_r | illegal_s;
    end
  end

  assign offset   = offset_r;
  assign shift_en = shift_en_r;
  assign running  = running_r;
  assign err      = err_r;

endmodule
